div_sequencer: RTL and testbench

//  Controller for the shared pipelined signed/unsigned divider pair behind the ALU's DIV/DIVU/REM/REMU ops.

---
 rtl/cpu_div_pkg.sv | 33 +++
 rtl/div_fixup.sv | 32 +++
 rtl/div_sequencer.sv | 173 +++++++++++++++++
 tb/tb_div_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_div_pkg.sv
// cpu_div_pkg: shared definitions for the divide sequencer slice.
//   - div_op_t    : ALU divide op codes (DIV, DIVU, REM, REMU)
//   - div_state_t : sequencer FSM state encoding (IDLE, WAIT, RESP)
//   - INT_MIN / ALL_ONES : operand/result constants used by the special cases
//   - op_is_signed / op_is_rem : op-code field decoders
package cpu_div_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } div_state_t;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // Bit 0 of the op code selects unsigned, bit 1 selects remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_fixup.sv
// div_fixup: combinational detection of the divide cases that never go to
// the dividers, together with their architectural result.
//   op    in  2   divide op code (div_op_t encoding)
//   a     in  32  dividend
//   b     in  32  divisor
//   hit   out 1   operands form a special case
//   value out 32  result for the special case (0 when hit is low)
// Divide by zero : DIV/DIVU -> all ones, REM/REMU -> dividend.
// Signed overflow: INT_MIN / -1 -> DIV gives INT_MIN, REM gives 0.
module div_fixup
  import cpu_div_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        hit,
  output logic [31:0] value
);

  always_comb begin
    hit   = 1'b0;
    value = '0;
    if (b == '0) begin
      hit   = 1'b1;
      value = op_is_rem(op) ? a : ALL_ONES;
    end else if (op_is_signed(op) && (a == INT_MIN) && (b == ALL_ONES)) begin
      hit   = 1'b1;
      value = op_is_rem(op) ? '0 : INT_MIN;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: controller for the shared pipelined signed/unsigned divider
// pair behind DIV/DIVU/REM/REMU. One request at a time; operands are held on
// o_div_numer/o_div_denom while the dividers work, and the selected result is
// returned as a single-cycle pulse.
//
// Handshake: a request is accepted on a rising edge where i_req_valid and
// o_req_ready are both high. o_req_ready is high only in IDLE with i_flush low
// and reset released. The response has no backpressure: o_resp_valid is high
// for exactly one cycle and o_result stays valid until the next response.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_req_valid/o_req_ready   request handshake; i_op, i_a, i_b request data
//   i_flush                   abort an in-flight op (no response)
//   o_resp_valid, o_result    response pulse and held result
//   o_busy                    high while waiting on the dividers
//   o_div_numer/o_div_denom   operands to both dividers
//   i_sdiv_*, i_udiv_*        quotient/remainder from the two dividers
//   o_dbg_state               current FSM state (div_state_t encoding)
//
// Parameters: LATENCY = divider pipeline depth (>= 1).
// Optional build macro DIV_SEQ_CACHE_EN: one-entry cache of the last normal
// completion so DIV followed by REM of the same operands answers in one cycle.
module div_sequencer
  import cpu_div_pkg::*;
#(
  parameter int LATENCY = 20
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_flush,
  output logic        o_resp_valid,
  output logic [31:0] o_result,
  output logic        o_busy,
  output logic [31:0] o_div_numer,
  output logic [31:0] o_div_denom,
  input  logic [31:0] i_sdiv_quot,
  input  logic [31:0] i_sdiv_rem,
  input  logic [31:0] i_udiv_quot,
  input  logic [31:0] i_udiv_rem,
  output logic [1:0]  o_dbg_state
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [31:0]      numer_q, denom_q, result_q;

  logic        accept;
  logic        fix_hit;
  logic [31:0] fix_val;
  logic        cache_hit;
  logic [31:0] cache_val;
  logic [31:0] div_sel;
  logic        div_done;

  div_fixup u_fixup (
    .op    (i_op),
    .a     (i_a),
    .b     (i_b),
    .hit   (fix_hit),
    .value (fix_val)
  );

  assign o_req_ready = (state_q == IDLE) && !i_flush && i_rst_n;
  assign accept      = i_req_valid && o_req_ready;

  // Last WAIT cycle that is not being flushed: divider outputs are sampled now.
  assign div_done = (state_q == WAIT) && !i_flush && (cnt_q == '0);

  always_comb begin
    div_sel = '0;
    case ({op_is_signed(op_q), op_is_rem(op_q)})
      2'b10:   div_sel = i_sdiv_quot;
      2'b11:   div_sel = i_sdiv_rem;
      2'b00:   div_sel = i_udiv_quot;
      default: div_sel = i_udiv_rem;
    endcase
  end

`ifdef DIV_SEQ_CACHE_EN
  logic        c_valid;
  logic        c_signed;
  logic [31:0] c_a, c_b, c_quot, c_rem;

  // Special cases take priority in the accept logic, so they never reach here.
  assign cache_hit = c_valid && (c_a == i_a) && (c_b == i_b) &&
                     (c_signed == op_is_signed(i_op));
  assign cache_val = op_is_rem(i_op) ? c_rem : c_quot;

  // Flush does not touch the entry; only reset invalidates it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c_valid  <= 1'b0;
      c_signed <= 1'b0;
      c_a      <= '0;
      c_b      <= '0;
      c_quot   <= '0;
      c_rem    <= '0;
    end else if (div_done) begin
      c_valid  <= 1'b1;
      c_signed <= op_is_signed(op_q);
      c_a      <= numer_q;
      c_b      <= denom_q;
      c_quot   <= op_is_signed(op_q) ? i_sdiv_quot : i_udiv_quot;
      c_rem    <= op_is_signed(op_q) ? i_sdiv_rem  : i_udiv_rem;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_val = '0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (fix_hit || cache_hit) state_d = RESP;
          else                      state_d = WAIT;
        end
      end
      WAIT: begin
        // Flush wins over completion in the same cycle.
        if (i_flush)            state_d = IDLE;
        else if (cnt_q == '0)   state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      numer_q  <= '0;
      denom_q  <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= i_op;
        numer_q <= i_a;
        denom_q <= i_b;
        cnt_q   <= CNT_LOAD;
        if (fix_hit)        result_q <= fix_val;
        else if (cache_hit) result_q <= cache_val;
      end else if ((state_q == WAIT) && !i_flush) begin
        if (cnt_q == '0) result_q <= div_sel;
        else             cnt_q    <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign o_resp_valid = (state_q == RESP);
  assign o_busy       = (state_q == WAIT);
  assign o_result     = result_q;
  assign o_div_numer  = numer_q;
  assign o_div_denom  = denom_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer. The two dividers are modelled as pipelines whose
// output is valid LATENCY edges after operands launch; they return junk for the
// special cases so the sequencer must bypass them. Expected results and
// latencies come from a spec-level reference model (plain arithmetic plus a
// mirror of the optional result cache).
module tb_div_sequencer;

  localparam int LATENCY = 20;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [1:0]  i_op;
  logic [31:0] i_a, i_b;
  logic        i_flush;
  logic        o_resp_valid;
  logic [31:0] o_result;
  logic        o_busy;
  logic [31:0] o_div_numer, o_div_denom;
  logic [31:0] i_sdiv_quot, i_sdiv_rem, i_udiv_quot, i_udiv_rem;
  logic [1:0]  o_dbg_state;

  div_sequencer #(.LATENCY(LATENCY)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_op         (i_op),
    .i_a          (i_a),
    .i_b          (i_b),
    .i_flush      (i_flush),
    .o_resp_valid (o_resp_valid),
    .o_result     (o_result),
    .o_busy       (o_busy),
    .o_div_numer  (o_div_numer),
    .o_div_denom  (o_div_denom),
    .i_sdiv_quot  (i_sdiv_quot),
    .i_sdiv_rem   (i_sdiv_rem),
    .i_udiv_quot  (i_udiv_quot),
    .i_udiv_rem   (i_udiv_rem),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_signed_op(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic bit is_rem_op(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, b);
    if (b == 32'd0) return 1'b1;
    return is_signed_op(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] arith(input bit sgn, input bit rem, input logic [31:0] a, b);
    if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem ? (a % b) : (a / b);
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, b);
    if (b == 32'd0) return is_rem_op(op) ? a : 32'hFFFF_FFFF;
    if (is_special(op, a, b)) return is_rem_op(op) ? 32'd0 : 32'h8000_0000;
    return arith(is_signed_op(op), is_rem_op(op), a, b);
  endfunction

  // Divider stand-in: junk on operands the sequencer must never forward.
  function automatic logic [31:0] div_model(input bit sgn, input bit rem, input logic [31:0] a, b);
    if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
      return 32'h0BAD_0BAD ^ {31'd0, rem};
    return arith(sgn, rem, a, b);
  endfunction

  // Cache mirror: last normal completion.
  bit          m_valid = 1'b0;
  bit          m_sgn;
  logic [31:0] m_a, m_b;
  logic [31:0] last_result = 32'd0;

  // ---------------- divider pipelines ----------------
  logic [63:0] pipe [LATENCY-1];
  always @(posedge i_clk) begin
    pipe[0] <= {o_div_numer, o_div_denom};
    for (int i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign i_sdiv_quot = div_model(1'b1, 1'b0, pipe[LATENCY-2][63:32], pipe[LATENCY-2][31:0]);
  assign i_sdiv_rem  = div_model(1'b1, 1'b1, pipe[LATENCY-2][63:32], pipe[LATENCY-2][31:0]);
  assign i_udiv_quot = div_model(1'b0, 1'b0, pipe[LATENCY-2][63:32], pipe[LATENCY-2][31:0]);
  assign i_udiv_rem  = div_model(1'b0, 1'b1, pipe[LATENCY-2][63:32], pipe[LATENCY-2][31:0]);

  // ---------------- driver tasks ----------------
  // Latency = number of rising edges from the accept edge to the edge at
  // which the consumer captures the pulse.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, b, input bit flush_resp);
    int n, exp_lat, bad;
    bit fast;
    logic [31:0] exp_r;
    exp_r = ref_result(op, a, b);
    fast  = is_special(op, a, b);
`ifdef DIV_SEQ_CACHE_EN
    if (!fast && m_valid && m_a == a && m_b == b && m_sgn == is_signed_op(op)) fast = 1'b1;
`endif
    exp_lat = fast ? 1 : LATENCY + 1;
    i_req_valid = 1'b1; i_op = op; i_a = a; i_b = b;
    #1;
    check("ready_idle", 32'(o_req_ready), 32'd1);
    exp_q.push_back(exp_r);
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_op = 2'($urandom_range(0, 3));
    n = 0; bad = 0;
    while (!o_resp_valid && n < LATENCY + 5) begin
      if (o_req_ready || !o_busy) bad++;
      if (o_div_numer != a || o_div_denom != b) bad++;
      @(negedge i_clk);
      n++;
    end
    check("latency", 32'(n + 1), 32'(exp_lat));
    check("wait_phase", 32'(bad), 32'd0);
    check("operands_held", o_div_numer ^ o_div_denom, a ^ b);
    if (flush_resp) begin
      i_flush = 1'b1;
      #1;
      check("resp_ignores_flush", 32'(o_resp_valid), 32'd1);
    end
    check("result", o_result, exp_q.pop_front());
    check("ready_in_resp", 32'(o_req_ready), 32'd0);
    @(negedge i_clk);
    i_flush = 1'b0;
    #1;
    check("pulse_width", 32'(o_resp_valid), 32'd0);
    check("ready_after", 32'(o_req_ready), 32'd1);
    check("result_hold", o_result, exp_r);
    if (!is_special(op, a, b) && exp_lat == LATENCY + 1) begin
      m_valid = 1'b1; m_a = a; m_b = b; m_sgn = is_signed_op(op);
    end
    last_result = exp_r;
  endtask

  task automatic watch_no_pulse(input string tag);
    int pulses = 0;
    repeat (LATENCY + 3) begin
      @(negedge i_clk);
      if (o_resp_valid) pulses++;
    end
    check(tag, 32'(pulses), 32'd0);
  endtask

  // Accept a normal op, then raise i_flush at WAIT cycle 'at'.
  task automatic run_flush(input logic [1:0] op, input logic [31:0] a, b, input int at);
    i_req_valid = 1'b1; i_op = op; i_a = a; i_b = b;
    #1;
    check("flush_ready_idle", 32'(o_req_ready), 32'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    repeat (at - 1) @(negedge i_clk);
    i_flush = 1'b1;
    #1;
    check("flush_busy", 32'(o_busy), 32'd1);
    check("flush_ready_low", 32'(o_req_ready), 32'd0);
    @(negedge i_clk);
    i_flush = 1'b0;
    #1;
    check("flush_idle_busy", 32'(o_busy), 32'd0);
    check("flush_ready_next", 32'(o_req_ready), 32'd1);
    watch_no_pulse("flush_no_pulse");
    check("flush_result_hold", o_result, last_result);
  endtask

  // Accept a normal op, then assert reset at WAIT cycle 'at'.
  task automatic run_reset(input logic [1:0] op, input logic [31:0] a, b, input int at);
    i_req_valid = 1'b1; i_op = op; i_a = a; i_b = b;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    repeat (at - 1) @(negedge i_clk);
    check("rst_pre_busy", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_resp", 32'(o_resp_valid), 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_ready", 32'(o_req_ready), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check("rst_ready_after", 32'(o_req_ready), 32'd1);
    m_valid = 1'b0;
    last_result = 32'd0;
    watch_no_pulse("rst_no_pulse");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_op = 2'd0; i_a = '0; i_b = '0; i_flush = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_ready_low", 32'(o_req_ready), 32'd0);
    i_rst_n = 1'b1;
    #1;
    check("reset_ready", 32'(o_req_ready), 32'd1);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_resp", 32'(o_resp_valid), 32'd0);
    check("reset_result", o_result, 32'd0);
    check("reset_numer", o_div_numer | o_div_denom, 32'd0);
    check("reset_state", 32'(o_dbg_state), 32'd0);

    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(OP_DIVU, 32'd5, 32'd0, 1'b0);
    run_op(OP_REMU, 32'd5, 32'd0, 1'b1);
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    run_flush(OP_DIVU, 32'd100, 32'd7, 5);
    run_op(OP_REMU, 32'd10, 32'd3, 1'b0);

    // Request while flushing in IDLE must be refused.
    @(negedge i_clk);
    i_req_valid = 1'b1; i_op = OP_DIV; i_a = 32'd77; i_b = 32'd5; i_flush = 1'b1;
    #1;
    check("idle_flush_ready", 32'(o_req_ready), 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0; i_flush = 1'b0;
    #1;
    check("idle_flush_busy", 32'(o_busy), 32'd0);
    watch_no_pulse("idle_flush_no_pulse");

    run_reset(OP_DIV, 32'd1000, 32'd9, 10);

    run_op(OP_DIV, 32'd100, 32'd7, 1'b0);
    run_op(OP_REM, 32'd100, 32'd7, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 200);
        2:       a = -$urandom_range(1, 200);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 16);
        3:       b = -$urandom_range(1, 16);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0 && m_valid) begin
        a = m_a; b = m_b;
      end
      run_op(op, a, b, 1'($urandom_range(0, 1)));
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
